// File: rtl/i2c_target_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_target_regs: I2C target with pointer-addressed byte register file.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module i2c_target_regs #(
   parameter logic [6:0] DeviceAddress = 7'h68,
   parameter int         NrOfRegisters = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       scl,
   inout  wire                        sda,
   output logic [NrOfRegisters*8-1:0] registers,
   output logic                       writeStrobe,
   output logic [7:0]                 writeIndex,
   output logic                       busy
);

   localparam int         c_IW   = (NrOfRegisters > 1) ? $clog2(NrOfRegisters) : 1;
   localparam logic [8:0] c_NREG = 9'(NrOfRegisters);

   typedef enum logic [3:0] {
      S_IDLE        = 4'd0,
      S_ADDRESS     = 4'd1,
      S_ACK_ADDRESS = 4'd2,
      S_POINTER     = 4'd3,
      S_ACK_POINTER = 4'd4,
      S_WRITE_DATA  = 4'd5,
      S_ACK_WRITE   = 4'd6,
      S_READ_DATA   = 4'd7,
      S_MASTER_ACK  = 4'd8
   } state_t;

   logic       r_scl_s1, r_scl_s2, r_scl_h;
   logic       r_sda_s1, r_sda_s2, r_sda_h;
   state_t     r_state, w_state_nxt;
   logic [3:0] r_bitcnt, w_bitcnt_nxt;
   logic [7:0] r_shift, w_shift_nxt;
   logic [7:0] r_pointer, w_pointer_nxt;
   logic       r_sda_low, w_sda_low_nxt;
   logic       r_busy, w_busy_nxt;
   logic       r_strobe, w_strobe_nxt;
   logic [7:0] r_index, w_index_nxt;
   logic       w_we;
   logic [7:0] r_regs [NrOfRegisters];

   logic            w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [c_IW-1:0] w_idx;
   logic [7:0]      w_rd_byte, w_ptr_inc;

   assign w_scl_rise = r_scl_s2 & ~r_scl_h;
   assign w_scl_fall = ~r_scl_s2 & r_scl_h;
   assign w_start    = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
   assign w_stop     = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
   assign w_idx      = r_pointer[c_IW-1:0];
   assign w_rd_byte  = r_regs[w_idx];
   assign w_ptr_inc  = ({1'b0, r_pointer} == c_NREG - 9'd1) ? 8'd0 : r_pointer + 8'd1;

   // Open-drain: only ever pull low or release.
   assign sda         = r_sda_low ? 1'b0 : 1'bz;
   assign writeStrobe = r_strobe;
   assign writeIndex  = r_index;
   assign busy        = r_busy;

   for (genvar gi = 0; gi < NrOfRegisters; gi++) begin : g_flat
      assign registers[gi*8 +: 8] = r_regs[gi];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         {r_scl_s1, r_scl_s2, r_scl_h} <= 3'b111;
         {r_sda_s1, r_sda_s2, r_sda_h} <= 3'b111;
         r_state   <= S_IDLE;
         r_bitcnt  <= 4'd0;
         r_shift   <= 8'd0;
         r_pointer <= 8'd0;
         r_sda_low <= 1'b0;
         r_busy    <= 1'b0;
         r_strobe  <= 1'b0;
         r_index   <= 8'd0;
         for (int i = 0; i < NrOfRegisters; i++) r_regs[i] <= 8'd0;
      end else begin
         {r_scl_s1, r_scl_s2, r_scl_h} <= {scl, r_scl_s1, r_scl_s2};
         {r_sda_s1, r_sda_s2, r_sda_h} <= {sda, r_sda_s1, r_sda_s2};
         r_state   <= w_state_nxt;
         r_bitcnt  <= w_bitcnt_nxt;
         r_shift   <= w_shift_nxt;
         r_pointer <= w_pointer_nxt;
         r_sda_low <= w_sda_low_nxt;
         r_busy    <= w_busy_nxt;
         r_strobe  <= w_strobe_nxt;
         r_index   <= w_index_nxt;
         if (w_we) r_regs[w_idx] <= r_shift;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_bitcnt_nxt  = r_bitcnt;
      w_shift_nxt   = r_shift;
      w_pointer_nxt = r_pointer;
      w_sda_low_nxt = r_sda_low;
      w_busy_nxt    = r_busy;
      w_strobe_nxt  = 1'b0;
      w_index_nxt   = r_index;
      w_we          = 1'b0;
      if (w_start) begin
         w_state_nxt   = S_ADDRESS;
         w_bitcnt_nxt  = 4'd0;
         w_sda_low_nxt = 1'b0;
      end else if (w_stop) begin
         w_state_nxt   = S_IDLE;
         w_sda_low_nxt = 1'b0;
         w_busy_nxt    = 1'b0;
      end else begin
         case (r_state)
            S_ADDRESS, S_POINTER, S_WRITE_DATA: begin
               if (w_scl_rise && r_bitcnt != 4'd8) begin
                  w_shift_nxt  = {r_shift[6:0], r_sda_s2};
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
               end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                  // A full byte is in; act on it at the falling edge so ACK timing is legal.
                  w_bitcnt_nxt = 4'd0;
                  if (r_state == S_ADDRESS) begin
                     if (r_shift[7:1] == DeviceAddress) begin
                        w_state_nxt   = S_ACK_ADDRESS;
                        w_sda_low_nxt = 1'b1;
                        w_busy_nxt    = 1'b1;
                     end else begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                     end
                  end else if (r_state == S_POINTER) begin
                     if ({1'b0, r_shift} < c_NREG) begin
                        w_pointer_nxt = r_shift;
                        w_state_nxt   = S_ACK_POINTER;
                        w_sda_low_nxt = 1'b1;
                     end else begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                     end
                  end else begin
                     w_we          = 1'b1;
                     w_strobe_nxt  = 1'b1;
                     w_index_nxt   = r_pointer;
                     w_pointer_nxt = w_ptr_inc;
                     w_state_nxt   = S_ACK_WRITE;
                     w_sda_low_nxt = 1'b1;
                  end
               end
            end
            S_ACK_ADDRESS: begin
               if (w_scl_fall) begin
                  w_bitcnt_nxt = 4'd0;
                  if (r_shift[0]) begin
                     w_shift_nxt   = w_rd_byte;
                     w_sda_low_nxt = ~w_rd_byte[7];
                     w_state_nxt   = S_READ_DATA;
                  end else begin
                     w_sda_low_nxt = 1'b0;
                     w_state_nxt   = S_POINTER;
                  end
               end
            end
            S_ACK_POINTER, S_ACK_WRITE: begin
               if (w_scl_fall) begin
                  w_sda_low_nxt = 1'b0;
                  w_state_nxt   = S_WRITE_DATA;
               end
            end
            S_READ_DATA: begin
               if (w_scl_rise) begin
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
               end else if (w_scl_fall) begin
                  if (r_bitcnt == 4'd8) begin
                     w_sda_low_nxt = 1'b0;
                     w_state_nxt   = S_MASTER_ACK;
                  end else begin
                     w_shift_nxt   = {r_shift[6:0], 1'b0};
                     w_sda_low_nxt = ~r_shift[6];
                  end
               end
            end
            S_MASTER_ACK: begin
               // Count value 9 marks "master ACKed, reload at the next falling edge".
               if (w_scl_rise) begin
                  if (r_sda_s2) begin
                     w_state_nxt = S_IDLE;
                     w_busy_nxt  = 1'b0;
                  end else begin
                     w_pointer_nxt = w_ptr_inc;
                     w_bitcnt_nxt  = 4'd9;
                  end
               end else if (w_scl_fall && r_bitcnt == 4'd9) begin
                  w_shift_nxt   = w_rd_byte;
                  w_sda_low_nxt = ~w_rd_byte[7];
                  w_bitcnt_nxt  = 4'd0;
                  w_state_nxt   = S_READ_DATA;
               end
            end
            default: begin
               w_sda_low_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`default_nettype none
// Directed-vector bench for i2c_target_regs: bit-banged I2C master plus register model.
module tb_i2c_target_regs;
   localparam int Q = 10;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        scl_drv = 1'b1;
   logic        m_sda_low = 1'b0;
   wire         sda;
   logic [63:0] registers;
   logic        writeStrobe;
   logic [7:0]  writeIndex;
   logic        busy;

   pullup (sda);
   assign sda = m_sda_low ? 1'b0 : 1'bz;

   always #5 clock = ~clock;

   i2c_target_regs #(.DeviceAddress(7'h68), .NrOfRegisters(8)) dut (
      .clock(clock), .reset(reset), .scl(scl_drv), .sda(sda),
      .registers(registers), .writeStrobe(writeStrobe), .writeIndex(writeIndex), .busy(busy)
   );

   typedef struct packed {
      bit         rd;
      logic [6:0] addr;
      logic [7:0] ptr;
      logic [7:0] d0;
      logic [7:0] d1;
      bit         wdata;
      bit         e_aack;
      bit         e_pack;
      bit         e_dack;
      logic [7:0] e0;
      logic [7:0] e1;
      int         e_nstb;
      logic [7:0] e_idx0;
      logic [7:0] e_idx1;
      bit         e_busy;
   } vec_t;

   int         n_vec = 0;
   int         n_fail = 0;
   int         n_strobe = 0;
   logic [7:0] idx_q[$];
   bit         target_drove = 1'b0;
   bit         busy_seen = 1'b0;
   logic [7:0] m_regs[8];

   always @(negedge clock) begin
      if (writeStrobe) begin
         n_strobe++;
         idx_q.push_back(writeIndex);
      end
      if (sda === 1'b0 && !m_sda_low) target_drove = 1'b1;
      if (busy) busy_seen = 1'b1;
   end

   function automatic logic [63:0] model_flat();
      logic [63:0] f;
      for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_regs[i];
      return f;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wq();
      repeat (Q) @(posedge clock);
   endtask

   task automatic bus_start();
      m_sda_low = 1'b0; wq();
      scl_drv = 1'b1;   wq();
      m_sda_low = 1'b1; wq();
      scl_drv = 1'b0;   wq();
   endtask

   task automatic bus_stop();
      m_sda_low = 1'b1; wq();
      scl_drv = 1'b1;   wq();
      m_sda_low = 1'b0; wq();
   endtask

   task automatic write_bit(input bit b);
      m_sda_low = ~b; wq();
      scl_drv = 1'b1; wq(); wq();
      scl_drv = 1'b0; wq();
   endtask

   task automatic read_bit(output bit b);
      m_sda_low = 1'b0; wq();
      scl_drv = 1'b1;   wq();
      #1 b = (sda !== 1'b0);
      wq();
      scl_drv = 1'b0;   wq();
   endtask

   task automatic write_byte(input logic [7:0] d, output bit ack);
      bit b;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(b);
      ack = ~b;
   endtask

   task automatic read_byte(output logic [7:0] d, input bit ack);
      bit b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(~ack);
   endtask

   vec_t       vecs[6];
   vec_t       v;
   bit         ack;
   logic [7:0] b0, b1;
   int         n0;

   initial begin
      //          rd  addr   ptr    d0     d1    wd  aa  pa  da  e0     e1    nstb idx0   idx1  busy
      vecs[0] = '{1'b0, 7'h68, 8'h02, 8'hAA, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 2, 8'h02, 8'h03, 1'b1};
      vecs[1] = '{1'b0, 7'h68, 8'h07, 8'h11, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 2, 8'h07, 8'h00, 1'b1};
      vecs[2] = '{1'b1, 7'h68, 8'h02, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, 8'h55, 0, 8'h00, 8'h00, 1'b1};
      vecs[3] = '{1'b1, 7'h68, 8'h07, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 8'h22, 0, 8'h00, 8'h00, 1'b1};
      vecs[4] = '{1'b0, 7'h50, 8'h02, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1'b0};
      vecs[5] = '{1'b0, 7'h68, 8'h09, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1'b1};
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;

      repeat (5) @(posedge clock);
      reset = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      check("reset_registers", registers, 64'd0);
      check("reset_busy", busy, 0);
      check("reset_strobe", writeStrobe, 0);
      check("reset_index", writeIndex, 0);
      check("reset_sda", sda, 1);

      for (int k = 0; k < 6; k++) begin
         v = vecs[k];
         n0 = n_strobe;
         idx_q.delete();
         target_drove = 1'b0;
         busy_seen = 1'b0;
         bus_start();
         write_byte({v.addr, 1'b0}, ack);
         check($sformatf("v%0d_addr_ack", k), ack, v.e_aack);
         write_byte(v.ptr, ack);
         check($sformatf("v%0d_ptr_ack", k), ack, v.e_pack);
         if (!v.rd && v.wdata) begin
            write_byte(v.d0, ack);
            check($sformatf("v%0d_d0_ack", k), ack, v.e_dack);
            write_byte(v.d1, ack);
            check($sformatf("v%0d_d1_ack", k), ack, v.e_dack);
            if (v.e_dack) begin
               m_regs[int'(v.ptr) % 8] = v.d0;
               m_regs[(int'(v.ptr) + 1) % 8] = v.d1;
            end
         end else if (v.rd) begin
            bus_start();
            write_byte({v.addr, 1'b1}, ack);
            check($sformatf("v%0d_rd_addr_ack", k), ack, 1);
            read_byte(b0, 1'b1);
            read_byte(b1, 1'b0);
            check($sformatf("v%0d_rd_byte0", k), b0, v.e0);
            check($sformatf("v%0d_rd_byte1", k), b1, v.e1);
            check($sformatf("v%0d_sda_after_nack", k), sda, 1);
         end
         bus_stop();
         check($sformatf("v%0d_busy_after_stop", k), busy, 0);
         check($sformatf("v%0d_sda_after_stop", k), sda, 1);
         check($sformatf("v%0d_registers", k), registers, model_flat());
         check($sformatf("v%0d_strobe_count", k), n_strobe - n0, v.e_nstb);
         check($sformatf("v%0d_busy_seen", k), busy_seen, v.e_busy);
         check($sformatf("v%0d_target_drove", k), target_drove, v.e_aack);
         if (v.e_nstb == 2 && idx_q.size() == 2) begin
            check($sformatf("v%0d_index0", k), idx_q[0], v.e_idx0);
            check($sformatf("v%0d_index1", k), idx_q[1], v.e_idx1);
         end
      end

      // Pointer after the last read is 0 and the invalid pointer must not move it.
      bus_start();
      write_byte(8'hD1, ack);
      check("cur_read_addr_ack", ack, 1);
      read_byte(b0, 1'b0);
      check("cur_read_byte", b0, 8'h22);
      bus_stop();

      // STOP after 4 bits of a data byte.
      n0 = n_strobe;
      bus_start();
      write_byte(8'hD0, ack);
      check("abort_addr_ack", ack, 1);
      write_byte(8'h01, ack);
      check("abort_ptr_ack", ack, 1);
      for (int i = 0; i < 4; i++) write_bit(1'b1);
      bus_stop();
      check("abort_stop_sda", sda, 1);
      check("abort_stop_busy", busy, 0);
      check("abort_stop_registers", registers, model_flat());
      check("abort_stop_strobes", n_strobe - n0, 0);

      // Reset while the target drives the address ACK.
      bus_start();
      for (int i = 7; i >= 0; i--) write_bit(bit'(8'hD0 >> i));
      m_sda_low = 1'b0;
      repeat (2) @(posedge clock);
      #1 check("abort_ack_driven", sda, 0);
      check("abort_busy_during_ack", busy, 1);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("abort_reset_sda", sda, 1);
      check("abort_reset_busy", busy, 0);
      check("abort_reset_registers", registers, 64'd0);
      check("abort_reset_strobe", writeStrobe, 0);
      check("abort_reset_index", writeIndex, 0);
      repeat (3) @(posedge clock);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      bus_stop();

      // Target still works after the reset.
      bus_start();
      write_byte(8'hD0, ack);
      check("post_reset_addr_ack", ack, 1);
      write_byte(8'h04, ack);
      check("post_reset_ptr_ack", ack, 1);
      write_byte(8'h3C, ack);
      check("post_reset_data_ack", ack, 1);
      bus_stop();
      m_regs[4] = 8'h3C;
      check("post_reset_registers", registers, model_flat());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (slave) with an internal byte-register file. It is the far end of the bus from the board's I2C master.
- The master uses it for loopback verification, and the board exposes it as a configuration port (time/alarm settings for the clock design).
- It oversamples SCL/SDA with the system clock, decodes START/STOP/RESTART, matches a 7-bit address, and supports pointer-based writes and reads with auto-increment.

Parameters:
- DeviceAddress, 7'h68: 7-bit bus address this target answers to.
- NrOfRegisters, 8: number of 8-bit registers (1..256).

Ports:
- clock  input  1  system clock; must be ≥ 20× the SCL frequency.
- reset  input  1  asynchronous, active-high.
- scl  input  1  bus clock. Open-drain, externally pulled up; never driven by this block.
- sda  inout  1  bus data. Driven only to 0 or Z.
- registers  output  NrOfRegisters*8  flattened register file; register i occupies bits [8i+7:8i].
- writeStrobe  output  1  one-cycle pulse after each register written over I2C.
- writeIndex  output  8  index of the register just written; valid with writeStrobe.
- busy  output  1  high from an address-matched START until STOP / return to Idle.

Behaviour:
- Reset values:
  - sda released (Z); registers all 0; writeStrobe 0; writeIndex 0; busy 0.
  - Pointer 0; state Idle.
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer plus one history flop.
  - All decisions use the synchronized values; latency from pin to decision is 2–3 clocks.
- Bus conditions, all evaluated on the synchronized values:
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - Data bits are sampled on the scl rising edge.
  - sda changes are made only on the scl falling edge.
- States: Idle, Address, AckAddress, Pointer, AckPointer, WriteData, AckWrite, ReadData, MasterAck.
- START (or RESTART) from any state → Address; bit counter cleared; sda released.
- STOP from any state → Idle; sda released; busy 0. A STOP mid-byte discards the partial byte.
- Address:
  - Shift 8 bits, MSB first.
  - If the upper 7 bits equal DeviceAddress, go to AckAddress.
  - On mismatch, go to Idle: no ACK, sda never driven until the next START.
- AckAddress:
  - Drive sda low from the falling edge after bit 8 to the next falling edge; busy goes 1.
  - R/W=0 → Pointer.
  - R/W=1 → ReadData: load registers[pointer] into the shifter and drive bit 7 at the ACK-release falling edge.
- Pointer (first byte after a write address):
  - Value < NrOfRegisters: set pointer, ACK, go to WriteData.
  - Value ≥ NrOfRegisters: NACK (sda released), pointer unchanged, go to Idle.
- WriteData:
  - After 8 bits, write registers[pointer], pulse writeStrobe with writeIndex=pointer, ACK (AckWrite).
  - Pointer then increments, wrapping NrOfRegisters-1 → 0.
- ReadData:
  - Shift registers[pointer] out MSB first, releasing sda for 1 bits.
  - After bit 0, release sda → MasterAck; sample master ACK on the rising edge.
  - ACK (0): pointer increments with wrap; load the next byte; continue in ReadData.
  - NACK (1): go to Idle and wait for STOP; sda released.
- Pointer persists across transactions. A write of only the pointer byte followed by RESTART+read returns registers[pointer].
- Reset asserted mid-transfer releases sda immediately (asynchronous) and forces all reset values.
- Clock stretching is not used: scl is never held.

Test Plan:
- Address mismatch: write to 7'h50 with 2 data bytes → sda never 0 from the target; registers unchanged; busy stays 0; writeStrobe never pulses.
- Burst write: START, 0xD0, 0x02, 0xAA, 0x55, STOP → 4 ACKs; registers[2]=0xAA, registers[3]=0x55; writeStrobe pulses twice with writeIndex 2 then 3.
- Wrap on write: pointer 0x07, data 0x11, 0x22 → registers[7]=0x11, registers[0]=0x22.
- Random read: START, 0xD0, 0x02, RESTART, 0xD1, read 2 bytes with ACK then NACK, STOP → bytes 0xAA, 0x55; sda released after the NACK; busy falls at STOP.
- Invalid pointer: START, 0xD0, 0x09, STOP → ACK on address, NACK on 0x09; pointer unchanged (a following read returns the old pointer's register).
- Abort: STOP inserted after 4 bits of a data byte, and separately reset asserted while the target is driving ACK → no register change, sda Z within 3 clocks (reset: immediately), state Idle.
